counter_irq_ctrl: RTL and testbench
===================================

COUNTER_IRQ_CTRL -- requirements
Module: counter_irq_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 counter0_OUT, counter1_OUT, counter2_OUT  input  1 each  timer channel outputs, asynchronous to clk.
REQ-005 reg_we  input  1  register write strobe, one clk cycle per write.
REQ-006 reg_addr  input  3  register select: 0 STATUS, 1 MASK, 2 AREN, 4/5/6 RELOAD0/1/2.
REQ-007 reg_wdata  input  32  register write data.
REQ-008 reg_rdata  output  32  register read data.
REQ-009 irq  output  1  interrupt request to CPU.
REQ-010 counter_we  output  1  timer write strobe.
REQ-011 counter_ch  output  2  timer channel select; only values 0-2 driven.
REQ-012 counter_val  output  32  timer reload value.

Function
REQ-013 Each counterN_OUT SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is synchronized-new=1 and history=0.
REQ-014 A synchronized rising edge on channel N SHALL set pending[N] on the same edge it is detected, 3 clk edges after the input is first sampled high.
REQ-015 Falling edges and steady levels SHALL NOT set pending.
REQ-016 STATUS write SHALL be write-1-to-clear on pending[2:0]; bits [31:3] ignored.
REQ-017 If a rising edge and a W1C clear hit the same channel in the same cycle, set SHALL win.
REQ-018 MASK[2:0] and AREN[2:0] SHALL be plain read/write; RELOADn SHALL be full 32-bit read/write.
REQ-019 reg_rdata SHALL be combinational from reg_addr: STATUS={29'b0,pending}, MASK, AREN zero-extended, RELOADn; addresses 3 and 7 read 0.
REQ-020 irq SHALL equal OR of (pending & MASK), driven from registered state only.
REQ-021 A rising edge on channel N with AREN[N]=1 SHALL set reload_req[N] together with pending[N].
REQ-022 Reload FSM states: IDLE, WRITE, GAP.
REQ-023 IDLE -> WRITE when any reload_req set; channel chosen by fixed priority 0 > 1 > 2; chosen req bit cleared on that transition.
REQ-024 In WRITE (exactly one cycle) counter_we=1, counter_ch=N, counter_val=RELOADN as sampled at IDLE->WRITE; then -> GAP.
REQ-025 In GAP (one cycle) counter_we=0; then -> IDLE; back-to-back reloads therefore spaced 2 cycles minimum.
REQ-026 counter_ch and counter_val SHALL hold last driven values outside WRITE.
REQ-027 A new edge on a channel whose req is being cleared in the same cycle SHALL leave req set (set wins).
REQ-028 Writing AREN[N]=0 SHALL NOT cancel an already-set reload_req[N].
REQ-029 Register writes to RELOADn during WRITE SHALL NOT alter the in-flight counter_val.

Reset
REQ-030 On rst=0, immediately: pending, MASK, AREN, reload_req, all RELOADn = 0; synchronizer and history flops = 0; FSM = IDLE.
REQ-031 During reset irq=0, counter_we=0, counter_ch=0, counter_val=0.
REQ-032 Reset asserted mid-WRITE SHALL drop counter_we to 0 asynchronously; no reload resumes after release.
REQ-033 A counterN_OUT already high at reset release SHALL register one rising edge (history starts at 0).

Verification
REQ-034 MASK=3'b001, pulse counter0_OUT high 5 cycles -> pending=3'b001 on 3rd edge after first sample, irq=1; STATUS write 1 -> pending=0, irq=0 next cycle.
REQ-035 MASK=0, pulse counter1_OUT -> STATUS reads 3'b010, irq stays 0; then MASK=3'b010 -> irq=1.
REQ-036 AREN=3'b111, RELOAD0=32'h10, RELOAD2=32'h20, simultaneous rising edges ch0 and ch2 -> counter_we pulse ch=0 val=32'h10, one GAP cycle, pulse ch=2 val=32'h20.
REQ-037 Same-cycle edge on ch1 and W1C of bit 1 -> pending[1] remains 1.
REQ-038 Assert rst during WRITE of ch0 reload -> counter_we=0 immediately, all registers 0, no counter_we after release with inputs low.

Source files
------------

// File: rtl/counter_irq_ctrl.sv
// Timer-channel interrupt and auto-reload controller: synchronises three timer
// outputs, latches rising edges as pending interrupts and re-arms timers on request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no reload in flight; picks the highest-priority reload_req
// ST_WRITE| counter_we high for one cycle with latched channel/value
// ST_GAP  | one quiet cycle before the next reload may be chosen
module counter_irq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        counter0_OUT,
   input  logic        counter1_OUT,
   input  logic        counter2_OUT,
   input  logic        reg_we,
   input  logic [2:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic        irq,
   output logic        counter_we,
   output logic [1:0]  counter_ch,
   output logic [31:0] counter_val
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_AREN   = 3'd2;

   logic [2:0]  sync1_q, sync1_d;
   logic [2:0]  sync2_q, sync2_d;
   logic [2:0]  hist_q, hist_d;
   logic [2:0]  pending_q, pending_d;
   logic [2:0]  mask_q, mask_d;
   logic [2:0]  aren_q, aren_d;
   logic [2:0]  req_q, req_d;
   logic [31:0] reload_q [3];
   logic [31:0] reload_d [3];
   state_t      state_q, state_d;
   logic        cnt_we_q, cnt_we_d;
   logic [1:0]  cnt_ch_q, cnt_ch_d;
   logic [31:0] cnt_val_q, cnt_val_d;

   logic [2:0]  rise;
   logic [2:0]  w1c;
   logic [2:0]  grant;

   always_comb begin
      sync1_d = {counter2_OUT, counter1_OUT, counter0_OUT};
      sync2_d = sync1_q;
      hist_d  = sync2_q;
      rise    = sync2_q & ~hist_q;

      w1c = 3'b000;
      if (reg_we && reg_addr == ADDR_STATUS) begin
         w1c = reg_wdata[2:0];
      end
      // A same-cycle edge outranks the software clear so no event is lost.
      pending_d = (pending_q & ~w1c) | rise;

      mask_d = mask_q;
      if (reg_we && reg_addr == ADDR_MASK) begin
         mask_d = reg_wdata[2:0];
      end
      aren_d = aren_q;
      if (reg_we && reg_addr == ADDR_AREN) begin
         aren_d = reg_wdata[2:0];
      end
      for (int i = 0; i < 3; i++) begin
         reload_d[i] = reload_q[i];
         if (reg_we && reg_addr == 3'(i + 4)) begin
            reload_d[i] = reg_wdata;
         end
      end

      state_d   = state_q;
      cnt_we_d  = 1'b0;
      cnt_ch_d  = cnt_ch_q;
      cnt_val_d = cnt_val_q;
      grant     = 3'b000;
      case (state_q)
         ST_IDLE: begin
            if (|req_q) begin
               state_d  = ST_WRITE;
               cnt_we_d = 1'b1;
               if (req_q[0]) begin
                  grant     = 3'b001;
                  cnt_ch_d  = 2'd0;
                  cnt_val_d = reload_q[0];
               end else if (req_q[1]) begin
                  grant     = 3'b010;
                  cnt_ch_d  = 2'd1;
                  cnt_val_d = reload_q[1];
               end else begin
                  grant     = 3'b100;
                  cnt_ch_d  = 2'd2;
                  cnt_val_d = reload_q[2];
               end
            end
         end
         ST_WRITE: state_d = ST_GAP;
         ST_GAP:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // AREN is sampled only when the edge arrives; clearing it later keeps the request.
      req_d = (req_q & ~grant) | (rise & aren_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= 3'b000;
         sync2_q   <= 3'b000;
         hist_q    <= 3'b000;
         pending_q <= 3'b000;
         mask_q    <= 3'b000;
         aren_q    <= 3'b000;
         req_q     <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            reload_q[i] <= 32'd0;
         end
         state_q   <= ST_IDLE;
         cnt_we_q  <= 1'b0;
         cnt_ch_q  <= 2'd0;
         cnt_val_q <= 32'd0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         hist_q    <= hist_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         aren_q    <= aren_d;
         req_q     <= req_d;
         for (int i = 0; i < 3; i++) begin
            reload_q[i] <= reload_d[i];
         end
         state_q   <= state_d;
         cnt_we_q  <= cnt_we_d;
         cnt_ch_q  <= cnt_ch_d;
         cnt_val_q <= cnt_val_d;
      end
   end

   always_comb begin
      reg_rdata = 32'd0;
      case (reg_addr)
         3'd0:    reg_rdata = {29'd0, pending_q};
         3'd1:    reg_rdata = {29'd0, mask_q};
         3'd2:    reg_rdata = {29'd0, aren_q};
         3'd4:    reg_rdata = reload_q[0];
         3'd5:    reg_rdata = reload_q[1];
         3'd6:    reg_rdata = reload_q[2];
         default: reg_rdata = 32'd0;
      endcase
   end

   assign irq         = |(pending_q & mask_q);
   assign counter_we  = cnt_we_q;
   assign counter_ch  = cnt_ch_q;
   assign counter_val = cnt_val_q;

endmodule

// File: tb/tb_counter_irq_ctrl.sv
// Directed bench for counter_irq_ctrl: edge detection, masking, W1C,
// auto-reload sequencing and asynchronous reset behaviour.
module tb_counter_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        c0 = 1'b0;
   logic        c1 = 1'b0;
   logic        c2 = 1'b0;
   logic        reg_we = 1'b0;
   logic [2:0]  reg_addr = 3'd0;
   logic [31:0] reg_wdata = 32'd0;
   logic [31:0] reg_rdata;
   logic        irq;
   logic        counter_we;
   logic [1:0]  counter_ch;
   logic [31:0] counter_val;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] d;

   counter_irq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .counter0_OUT (c0),
      .counter1_OUT (c1),
      .counter2_OUT (c2),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_rdata    (reg_rdata),
      .irq          (irq),
      .counter_we   (counter_we),
      .counter_ch   (counter_ch),
      .counter_val  (counter_val)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] v);
      reg_we    = 1'b1;
      reg_addr  = a;
      reg_wdata = v;
      tick();
      reg_we    = 1'b0;
      reg_wdata = 32'd0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      reg_addr = a;
      #1;
      v = reg_rdata;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({irq, counter_we, counter_ch, counter_val} !== 36'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got irq=%b we=%b ch=%0d val=%h, want all 0",
                  irq, counter_we, counter_ch, counter_val);
      end
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reg%0d: got %h want 0", a, d);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_pending_irq();
      wr(3'd1, 32'd1);
      c0 = 1'b1;
      tick();
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL pend_edge1: got %h want 0", d); end
      tick();
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL pend_edge2: got %h want 0", d); end
      tick();
      rd(3'd0, d);
      n_cmp++;
      if ({irq, d} !== {1'b1, 32'd1}) begin
         n_err++; $display("FAIL pend_edge3: got irq=%b status=%h want irq=1 status=1", irq, d);
      end
      tick();
      tick();
      c0 = 1'b0;
      repeat (5) tick();
      rd(3'd0, d);
      n_cmp++;
      if ({irq, d} !== {1'b1, 32'd1}) begin
         n_err++; $display("FAIL pend_after_fall: got irq=%b status=%h want irq=1 status=1", irq, d);
      end
      wr(3'd0, 32'd1);
      rd(3'd0, d);
      n_cmp++;
      if ({irq, d} !== {1'b0, 32'd0}) begin
         n_err++; $display("FAIL w1c_clear: got irq=%b status=%h want 0/0", irq, d);
      end
      repeat (4) tick();
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL no_retrigger: got %h want 0", d); end
   endtask

   task automatic test_mask_gate();
      wr(3'd1, 32'd0);
      c1 = 1'b1;
      repeat (3) tick();
      c1 = 1'b0;
      repeat (4) tick();
      rd(3'd0, d);
      n_cmp++;
      if ({irq, d} !== {1'b0, 32'd2}) begin
         n_err++; $display("FAIL masked_pend: got irq=%b status=%h want irq=0 status=2", irq, d);
      end
      wr(3'd1, 32'd2);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL unmask_irq: got %b want 1", irq); end
      rd(3'd1, d);
      n_cmp++;
      if (d !== 32'd2) begin n_err++; $display("FAIL mask_readback: got %h want 2", d); end
      wr(3'd0, 32'd2);
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL clear_irq1: got %b want 0", irq); end
   endtask

   task automatic test_regs();
      logic [31:0] exp_v [8];
      exp_v = '{32'd0, 32'd7, 32'd0, 32'd0, 32'hA5A5_0001, 32'h1234_5678, 32'hFFFF_0000, 32'd0};
      wr(3'd4, 32'hA5A5_0001);
      wr(3'd5, 32'h1234_5678);
      wr(3'd6, 32'hFFFF_0000);
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd2, 32'hFFFF_FFF8);
      wr(3'd3, 32'hFFFF_FFFF);
      wr(3'd7, 32'hFFFF_FFFF);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== exp_v[a]) begin
            n_err++; $display("FAIL regmap_%0d: got %h want %h", a, d, exp_v[a]);
         end
      end
      wr(3'd1, 32'd0);
   endtask

   task automatic test_set_wins();
      c1 = 1'b1;
      tick();
      tick();
      wr(3'd0, 32'd2);
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd2) begin n_err++; $display("FAIL set_beats_w1c: got %h want 2", d); end
      c1 = 1'b0;
      repeat (4) tick();
      wr(3'd0, 32'd2);
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL w1c_after: got %h want 0", d); end
   endtask

   task automatic test_back_to_back();
      int k;
      int extra;
      wr(3'd2, 32'd7);
      wr(3'd4, 32'h10);
      wr(3'd6, 32'h20);
      c0 = 1'b1;
      c2 = 1'b1;
      repeat (3) tick();
      rd(3'd0, d);
      n_cmp++;
      if ({counter_we, d} !== {1'b0, 32'd5}) begin
         n_err++; $display("FAIL reload_pend: got we=%b status=%h want we=0 status=5", counter_we, d);
      end
      tick();
      n_cmp++;
      if ({counter_we, counter_ch, counter_val} !== {1'b1, 2'd0, 32'h10}) begin
         n_err++; $display("FAIL reload_ch0: got we=%b ch=%0d val=%h want 1/0/10",
                           counter_we, counter_ch, counter_val);
      end
      wr(3'd4, 32'hDEAD_BEEF);
      n_cmp++;
      if ({counter_we, counter_ch, counter_val} !== {1'b0, 2'd0, 32'h10}) begin
         n_err++; $display("FAIL reload_gap_hold: got we=%b ch=%0d val=%h want 0/0/10",
                           counter_we, counter_ch, counter_val);
      end
      k = 0;
      while (!counter_we && k < 6) begin
         tick();
         k++;
      end
      n_cmp++;
      if ({counter_we, counter_ch, counter_val} !== {1'b1, 2'd2, 32'h20}) begin
         n_err++; $display("FAIL reload_ch2: got we=%b ch=%0d val=%h want 1/2/20 (waited %0d)",
                           counter_we, counter_ch, counter_val, k);
      end
      extra = 0;
      repeat (8) begin
         tick();
         if (counter_we) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL reload_extra: got %0d pulses want 0", extra); end
      n_cmp++;
      if ({counter_ch, counter_val} !== {2'd2, 32'h20}) begin
         n_err++; $display("FAIL reload_hold_idle: got ch=%0d val=%h want 2/20", counter_ch, counter_val);
      end
      c0 = 1'b0;
      c2 = 1'b0;
      repeat (4) tick();
      wr(3'd0, 32'd7);
   endtask

   task automatic test_reset_mid_write();
      int pulses;
      c0 = 1'b1;
      repeat (4) tick();
      n_cmp++;
      if ({counter_we, counter_val} !== {1'b1, 32'hDEAD_BEEF}) begin
         n_err++; $display("FAIL pre_reset_write: got we=%b val=%h want 1/deadbeef", counter_we, counter_val);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({irq, counter_we, counter_ch, counter_val} !== 36'd0) begin
         n_err++; $display("FAIL async_reset: got irq=%b we=%b ch=%0d val=%h want all 0",
                           irq, counter_we, counter_ch, counter_val);
      end
      c0 = 1'b0;
      for (int a = 0; a < 7; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== 32'd0) begin n_err++; $display("FAIL reset_clr_reg%0d: got %h want 0", a, d); end
      end
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (10) begin
         tick();
         if (counter_we) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin n_err++; $display("FAIL no_resume: got %0d pulses want 0", pulses); end
   endtask

   task automatic test_high_at_release();
      c2 = 1'b1;
      rst = 1'b0;
      #3;
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL release_edge2: got %h want 0", d); end
      tick();
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'd4) begin n_err++; $display("FAIL release_edge3: got %h want 4", d); end
      c2 = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_pending_irq();
      test_mask_gate();
      test_regs();
      test_set_wins();
      test_back_to_back();
      test_reset_mid_write();
      test_high_at_release();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
